// File: rtl/vx_bitmanip_pkg.sv
// vx_bitmanip_pkg: op encodings, byte statistics helper and XLEN
// limits shared by the Zbb-style bit-manipulation execute unit.
package vx_bitmanip_pkg;

  typedef enum logic [4:0] {
    BM_MIN   = 5'd0,
    BM_MAX   = 5'd1,
    BM_MINU  = 5'd2,
    BM_MAXU  = 5'd3,
    BM_ANDN  = 5'd4,
    BM_ORN   = 5'd5,
    BM_XNOR  = 5'd6,
    BM_ROL   = 5'd7,
    BM_ROR   = 5'd8,
    BM_CLZ   = 5'd9,
    BM_CTZ   = 5'd10,
    BM_CPOP  = 5'd11,
    BM_SEXTB = 5'd12,
    BM_SEXTH = 5'd13,
    BM_ZEXTH = 5'd14,
    BM_REV8  = 5'd15,
    BM_ORCB  = 5'd16
  } bm_op_e;

  localparam int XLEN_MIN  = 16;
  localparam int XLEN_GRAN = 8;

  typedef struct packed {
    logic       zero;
    logic [3:0] tz;
    logic [3:0] lz;
    logic [3:0] pop;
  } byte_stats_t;

  localparam int BS_W = $bits(byte_stats_t);

  function automatic bit xlen_ok(input int xlen);
    return (xlen >= XLEN_MIN) && (xlen % XLEN_GRAN == 0);
  endfunction

  function automatic byte_stats_t byte_stats(input logic [7:0] b);
    byte_stats_t s;
    logic        seen;
    s      = '0;
    s.zero = (b == 8'h00);
    for (int i = 0; i < 8; i++) begin
      s.pop = s.pop + 4'(b[i]);
    end
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      seen = seen | b[i];
      if (!seen) s.lz = s.lz + 4'd1;
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | b[i];
      if (!seen) s.tz = s.tz + 4'd1;
    end
    return s;
  endfunction

endpackage

// File: rtl/vx_bitmanip_lane.sv
// vx_bitmanip_lane: one SIMT lane; stage-1 result and byte partials,
// stage-2 count combine, result select and lane masking.
module vx_bitmanip_lane
  import vx_bitmanip_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]             op_i,
  input  logic [XLEN-1:0]        a_i,
  input  logic [XLEN-1:0]        b_i,
  output logic [XLEN-1:0]        s1_res_o,
  output logic [XLEN/8*BS_W-1:0] s1_stats_o,
  input  logic [4:0]             s2_op_i,
  input  logic [XLEN-1:0]        s2_res_i,
  input  logic [XLEN/8*BS_W-1:0] s2_stats_i,
  input  logic                   s2_en_i,
  output logic [XLEN-1:0]        s2_data_o
);

  localparam int NB  = XLEN / 8;
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]    sh;
  logic [2*XLEN-1:0] rol_w;
  logic [2*XLEN-1:0] ror_w;
  logic [XLEN-1:0]   rev;
  logic [XLEN-1:0]   orc;
  logic              slt;
  logic              ult;

  assign sh    = b_i[SHW-1:0];
  assign rol_w = {a_i, a_i} << sh;
  assign ror_w = {a_i, a_i} >> sh;
  assign slt   = $signed(a_i) < $signed(b_i);
  assign ult   = a_i < b_i;

  always_comb begin
    rev = '0;
    orc = '0;
    for (int i = 0; i < NB; i++) begin
      rev[8*i +: 8] = a_i[8*(NB-1-i) +: 8];
      orc[8*i +: 8] = {8{|a_i[8*i +: 8]}};
    end
  end

  always_comb begin
    s1_res_o = '0;
    case (op_i)
      BM_MIN:   s1_res_o = slt ? a_i : b_i;
      BM_MAX:   s1_res_o = slt ? b_i : a_i;
      BM_MINU:  s1_res_o = ult ? a_i : b_i;
      BM_MAXU:  s1_res_o = ult ? b_i : a_i;
      BM_ANDN:  s1_res_o = a_i & ~b_i;
      BM_ORN:   s1_res_o = a_i | ~b_i;
      BM_XNOR:  s1_res_o = ~(a_i ^ b_i);
      BM_ROL:   s1_res_o = rol_w[2*XLEN-1:XLEN];
      BM_ROR:   s1_res_o = ror_w[XLEN-1:0];
      BM_SEXTB: s1_res_o = {{(XLEN-8){a_i[7]}}, a_i[7:0]};
      BM_SEXTH: s1_res_o = {{(XLEN-16){a_i[15]}}, a_i[15:0]};
      BM_ZEXTH: s1_res_o = {{(XLEN-16){1'b0}}, a_i[15:0]};
      BM_REV8:  s1_res_o = rev;
      BM_ORCB:  s1_res_o = orc;
      default:  s1_res_o = '0;
    endcase
  end

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign s1_stats_o[i*BS_W +: BS_W] = byte_stats(a_i[8*i +: 8]);
  end

  byte_stats_t     st_lo;
  byte_stats_t     st_hi;
  logic            hit_t;
  logic            hit_l;
  logic [XLEN-1:0] pop;
  logic [XLEN-1:0] lz;
  logic [XLEN-1:0] tz;
  logic [XLEN-1:0] sel;

  // Zero bytes report lz = tz = 8, so the scan only stops past the
  // first non-zero byte and an all-zero word sums to XLEN.
  always_comb begin
    st_lo = '0;
    st_hi = '0;
    hit_t = 1'b0;
    hit_l = 1'b0;
    pop   = '0;
    lz    = '0;
    tz    = '0;
    for (int i = 0; i < NB; i++) begin
      st_lo = s2_stats_i[i*BS_W +: BS_W];
      st_hi = s2_stats_i[(NB-1-i)*BS_W +: BS_W];
      pop   = pop + XLEN'(st_lo.pop);
      if (!hit_t) tz = tz + XLEN'(st_lo.tz);
      if (!hit_l) lz = lz + XLEN'(st_hi.lz);
      hit_t = hit_t | !st_lo.zero;
      hit_l = hit_l | !st_hi.zero;
    end
  end

  always_comb begin
    sel = s2_res_i;
    case (s2_op_i)
      BM_CLZ:  sel = lz;
      BM_CTZ:  sel = tz;
      BM_CPOP: sel = pop;
      default: sel = s2_res_i;
    endcase
  end

  assign s2_data_o = s2_en_i ? sel : '0;

endmodule

// File: rtl/vx_bitmanip_unit.sv
// vx_bitmanip_unit: two-stage pipelined SIMT bit-manipulation unit
// with valid/ready handshakes and full backpressure.
module vx_bitmanip_unit
  import vx_bitmanip_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int UUID_W    = 44,
  parameter int WID_W     = 2,
  parameter int RD_W      = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [4:0]                op_in,
  input  logic [UUID_W-1:0]         uuid_in,
  input  logic [WID_W-1:0]          wid_in,
  input  logic [NUM_LANES-1:0]      tmask_in,
  input  logic [31:0]               PC_in,
  input  logic [RD_W-1:0]           rd_in,
  input  logic                      wb_in,
  input  logic                      use_imm_in,
  input  logic [XLEN-1:0]           imm_in,
  input  logic [NUM_LANES*XLEN-1:0] rs1_data_in,
  input  logic [NUM_LANES*XLEN-1:0] rs2_data_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [UUID_W-1:0]         uuid_out,
  output logic [WID_W-1:0]          wid_out,
  output logic [NUM_LANES-1:0]      tmask_out,
  output logic [31:0]               PC_out,
  output logic [RD_W-1:0]           rd_out,
  output logic                      wb_out,
  output logic [NUM_LANES*XLEN-1:0] data_out
);

  localparam int SW = XLEN / 8 * BS_W;

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("vx_bitmanip_unit: XLEN must be a multiple of 8, >= 16");
  end

  logic                 s1_valid_q, s1_valid_d;
  logic [4:0]           s1_op_q;
  logic [UUID_W-1:0]    s1_uuid_q;
  logic [WID_W-1:0]     s1_wid_q;
  logic [NUM_LANES-1:0] s1_tmask_q;
  logic [31:0]          s1_pc_q;
  logic [RD_W-1:0]      s1_rd_q;
  logic                 s1_wb_q;

  logic [NUM_LANES-1:0][XLEN-1:0] s1_res_d, s1_res_q;
  logic [NUM_LANES-1:0][SW-1:0]   s1_stats_d, s1_stats_q;
  logic [NUM_LANES-1:0][XLEN-1:0] out_data_d, out_data_q;

  logic                 out_valid_q, out_valid_d;
  logic [UUID_W-1:0]    out_uuid_q;
  logic [WID_W-1:0]     out_wid_q;
  logic [NUM_LANES-1:0] out_tmask_q;
  logic [31:0]          out_pc_q;
  logic [RD_W-1:0]      out_rd_q;
  logic                 out_wb_q;

  logic s2_free;
  logic s1_adv;
  logic accept;

  assign s2_free  = !out_valid_q || ready_out;
  assign s1_adv   = s1_valid_q && s2_free;
  assign ready_in = !s1_valid_q || s1_adv;
  assign accept   = valid_in && ready_in;

  assign s1_valid_d  = accept || (s1_valid_q && !s1_adv);
  assign out_valid_d = s1_adv || (out_valid_q && !ready_out);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [XLEN-1:0] b;
    assign b = use_imm_in ? imm_in : rs2_data_in[l*XLEN +: XLEN];
    vx_bitmanip_lane #(
      .XLEN(XLEN)
    ) u_lane (
      .op_i       (op_in),
      .a_i        (rs1_data_in[l*XLEN +: XLEN]),
      .b_i        (b),
      .s1_res_o   (s1_res_d[l]),
      .s1_stats_o (s1_stats_d[l]),
      .s2_op_i    (s1_op_q),
      .s2_res_i   (s1_res_q[l]),
      .s2_stats_i (s1_stats_q[l]),
      .s2_en_i    (s1_tmask_q[l]),
      .s2_data_o  (out_data_d[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload registers carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q    <= op_in;
      s1_uuid_q  <= uuid_in;
      s1_wid_q   <= wid_in;
      s1_tmask_q <= tmask_in;
      s1_pc_q    <= PC_in;
      s1_rd_q    <= rd_in;
      s1_wb_q    <= wb_in;
      s1_res_q   <= s1_res_d;
      s1_stats_q <= s1_stats_d;
    end
    if (s1_adv) begin
      out_uuid_q  <= s1_uuid_q;
      out_wid_q   <= s1_wid_q;
      out_tmask_q <= s1_tmask_q;
      out_pc_q    <= s1_pc_q;
      out_rd_q    <= s1_rd_q;
      out_wb_q    <= s1_wb_q;
      out_data_q  <= out_data_d;
    end
  end

  assign valid_out = out_valid_q;
  assign uuid_out  = out_uuid_q;
  assign wid_out   = out_wid_q;
  assign tmask_out = out_tmask_q;
  assign PC_out    = out_pc_q;
  assign rd_out    = out_rd_q;
  assign wb_out    = out_wb_q;
  assign data_out  = out_data_q;

endmodule

// File: tb/tb_vx_bitmanip_unit.sv
// tb_vx_bitmanip_unit: directed scoreboard bench for the
// bit-manipulation unit (NUM_LANES=4, XLEN=32).
module tb_vx_bitmanip_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         ready_in;
  logic [4:0]   op_in;
  logic [43:0]  uuid_in;
  logic [1:0]   wid_in;
  logic [3:0]   tmask_in;
  logic [31:0]  PC_in;
  logic [5:0]   rd_in;
  logic         wb_in;
  logic         use_imm_in;
  logic [31:0]  imm_in;
  logic [127:0] rs1_data_in;
  logic [127:0] rs2_data_in;
  logic         valid_out;
  logic         ready_out;
  logic [43:0]  uuid_out;
  logic [1:0]   wid_out;
  logic [3:0]   tmask_out;
  logic [31:0]  PC_out;
  logic [5:0]   rd_out;
  logic         wb_out;
  logic [127:0] data_out;

  always #5 clk = ~clk;

  vx_bitmanip_unit dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .op_in(op_in), .uuid_in(uuid_in), .wid_in(wid_in),
    .tmask_in(tmask_in), .PC_in(PC_in), .rd_in(rd_in),
    .wb_in(wb_in), .use_imm_in(use_imm_in), .imm_in(imm_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .uuid_out(uuid_out), .wid_out(wid_out),
    .tmask_out(tmask_out), .PC_out(PC_out), .rd_out(rd_out),
    .wb_out(wb_out), .data_out(data_out)
  );

  typedef struct {
    logic [127:0] data;
    logic [88:0]  tags;
    logic [43:0]  uuid;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   seq = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [4:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      5'd0: r = ($signed(a) < $signed(b)) ? a : b;
      5'd1: r = ($signed(a) > $signed(b)) ? a : b;
      5'd2: r = (a < b) ? a : b;
      5'd3: r = (a > b) ? a : b;
      5'd4: r = a & ~b;
      5'd5: r = a | ~b;
      5'd6: r = ~(a ^ b);
      5'd7: begin
        r = a;
        for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], r[31]};
      end
      5'd8: begin
        r = a;
        for (int k = 0; k < int'(b[4:0]); k++) r = {r[0], r[31:1]};
      end
      5'd9:  for (int k = 31; k >= 0 && !a[k]; k--) r++;
      5'd10: for (int k = 0; k < 32 && !a[k]; k++) r++;
      5'd11: for (int k = 0; k < 32; k++) r = r + 32'(a[k]);
      5'd12: r = {{24{a[7]}}, a[7:0]};
      5'd13: r = {{16{a[15]}}, a[15:0]};
      5'd14: r = {16'h0, a[15:0]};
      5'd15: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
      5'd16: for (int k = 0; k < 4; k++)
               r[8*k +: 8] = (a[8*k +: 8] != 8'h0) ? 8'hFF : 8'h00;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] rep(input logic [31:0] x);
    return {4{x}};
  endfunction

  task automatic drive(input logic [4:0] op, input logic [127:0] a,
                       input logic [127:0] b, input logic ui,
                       input logic [31:0] imm, input logic [3:0] m,
                       output exp_t e);
    logic [31:0] bl;
    valid_in    = 1'b1;
    op_in       = op;
    uuid_in     = 44'(seq) * 44'd3 + 44'd7;
    wid_in      = 2'(seq);
    tmask_in    = m;
    PC_in       = 32'h1000 + 32'(seq) * 32'd4;
    rd_in       = 6'(seq);
    wb_in       = ~seq[0];
    use_imm_in  = ui;
    imm_in      = imm;
    rs1_data_in = a;
    rs2_data_in = b;
    seq++;
    for (int l = 0; l < 4; l++) begin
      bl = ui ? imm : b[32*l +: 32];
      e.data[32*l +: 32] = m[l] ? ref_op(op, a[32*l +: 32], bl) : 32'h0;
    end
    e.uuid = uuid_in;
    e.tags = {uuid_in, wid_in, tmask_in, PC_in, rd_in, wb_in};
  endtask

  task automatic send(input logic [4:0] op, input logic [127:0] a,
                      input logic [127:0] b, input logic ui,
                      input logic [31:0] imm, input logic [3:0] m);
    exp_t e;
    int   n;
    drive(op, a, b, ui, imm, m, e);
    n = 0;
    while (!ready_in && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_in_time", 128'(n < 50), 128'd1);
    if (n < 50) q.push_back(e);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((q.size() != 0 || valid_out) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 128'(n < 100), 128'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      chk("out_expected", 128'(q.size() != 0), 128'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("data", data_out, e.data);
        chk("tags", 128'({uuid_out, wid_out, tmask_out, PC_out,
                          rd_out, wb_out}), 128'(e.tags));
      end
    end
  end

  localparam logic [127:0] CNT_A =
    {32'hF0F00001, 32'hFFFFFFFF, 32'h00010000, 32'h00000000};
  localparam logic [127:0] MIX_A =
    {32'h11223344, 32'h00120000, 32'hABCD1234, 32'h00000080};
  localparam logic [127:0] MIX_B =
    {32'h00000024, 32'h0000001F, 32'hFFFF0000, 32'h00000000};

  initial begin
    exp_t ea, eb, ec;
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    op_in = '0; uuid_in = '0; wid_in = '0; tmask_in = '0;
    PC_in = '0; rd_in = '0; wb_in = 1'b0; use_imm_in = 1'b0;
    imm_in = '0; rs1_data_in = '0; rs2_data_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_out", 128'(valid_out), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready_in", 128'(ready_in), 128'd1);
    chk("post_reset_valid_out", 128'(valid_out), 128'd0);
    @(posedge clk); #1;

    // Latency of a lone request
    send(5'd0, rep(32'h80000000), rep(32'h1), 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    chk("lat_cycle1", 128'(valid_out), 128'd0);
    @(negedge clk);
    chk("lat_cycle2", 128'(valid_out), 128'd1);
    @(posedge clk); #1;

    send(5'd1, rep(32'h80000000), rep(32'h1), 1'b0, 32'h0, 4'hF);
    send(5'd2, rep(32'h80000000), rep(32'h1), 1'b0, 32'h0, 4'hF);
    send(5'd3, rep(32'h80000000), rep(32'h1), 1'b0, 32'h0, 4'hF);

    send(5'd9,  CNT_A, '0, 1'b0, 32'h0, 4'hF);
    send(5'd10, CNT_A, '0, 1'b0, 32'h0, 4'hF);
    send(5'd11, CNT_A, '0, 1'b0, 32'h0, 4'hF);

    send(5'd15, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd16, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd8, rep(32'h1), MIX_B, 1'b1, 32'h1, 4'hF);
    send(5'd12, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd13, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd14, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd7, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd4, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd5, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd6, MIX_A, MIX_B, 1'b1, 32'h0F0F0F0F, 4'hF);
    send(5'd20, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF);
    send(5'd11, rep(32'hFF), rep(32'hFF), 1'b0, 32'h0, 4'b0101);
    wait_empty();

    // Backpressure: two requests fit, the third waits
    ready_out = 1'b0;
    drive(5'd15, MIX_A, MIX_B, 1'b0, 32'h0, 4'hF, ea);
    chk("bp_ready_a", 128'(ready_in), 128'd1);
    q.push_back(ea);
    @(posedge clk); #1;
    drive(5'd16, MIX_A, MIX_B, 1'b0, 32'h0, 4'b1011, eb);
    chk("bp_ready_b", 128'(ready_in), 128'd1);
    q.push_back(eb);
    @(posedge clk); #1;
    drive(5'd9, CNT_A, '0, 1'b0, 32'h0, 4'hF, ec);
    chk("bp_ready_c", 128'(ready_in), 128'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_ready", 128'(ready_in), 128'd0);
      chk("bp_hold_valid", 128'(valid_out), 128'd1);
      chk("bp_hold_data", data_out, ea.data);
      chk("bp_hold_uuid", 128'(uuid_out), 128'(ea.uuid));
    end
    @(posedge clk); #1;
    ready_out = 1'b1;
    #1;
    chk("bp_release_ready", 128'(ready_in), 128'd1);
    q.push_back(ec);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("bp_drain_b_valid", 128'(valid_out), 128'd1);
    chk("bp_drain_b_uuid", 128'(uuid_out), 128'(eb.uuid));
    @(negedge clk);
    chk("bp_drain_c_valid", 128'(valid_out), 128'd1);
    chk("bp_drain_c_uuid", 128'(uuid_out), 128'(ec.uuid));
    @(negedge clk);
    chk("bp_drain_done", 128'(valid_out), 128'd0);
    wait_empty();

    // Reset with two requests in flight
    ready_out = 1'b0;
    send(5'd0, rep(32'h5), rep(32'h6), 1'b0, 32'h0, 4'hF);
    send(5'd1, rep(32'h5), rep(32'h6), 1'b0, 32'h0, 4'hF);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("rst_flush_valid", 128'(valid_out), 128'd0);
    reset = 1'b0;
    ready_out = 1'b1;
    chk("rst_ready_in", 128'(ready_in), 128'd1);
    send(5'd11, CNT_A, '0, 1'b0, 32'h0, 4'b1110);
    @(negedge clk);
    chk("rst_lat_cycle1", 128'(valid_out), 128'd0);
    @(negedge clk);
    chk("rst_lat_cycle2", 128'(valid_out), 128'd1);
    @(negedge clk);
    chk("rst_alone", 128'(valid_out), 128'd0);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_bitmanip_unit.md
Name: vx_bitmanip_unit

Overview:
- Parametrised two-stage pipelined Zbb-style bit-manipulation execute unit; successor to the single-cycle min/max/sext logic folded into the ALU.
- Sits beside the ALU behind the issue dispatcher and returns results through a commit-style valid/ready port.
- Adds lane/XLEN parametrisation, count ops (CLZ/CTZ/CPOP), rotates, logic-with-negate, REV8/ORC.B, per-lane masking and full backpressure.

Parameters:
- NUM_LANES, 4, SIMT lanes (threads) processed per request.
- XLEN, 32, lane width; must be a multiple of 8 and at least 16.
- UUID_W, 44, trace tag width.
- WID_W, 2, warp-id width.
- RD_W, 6, destination register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  request valid
- ready_in  out  1  unit can accept a request this cycle
- op_in  in  5  operation, bm_op_e from vx_bitmanip_pkg
- uuid_in  in  UUID_W  trace tag
- wid_in  in  WID_W  warp id
- tmask_in  in  NUM_LANES  active lanes
- PC_in  in  32  instruction PC
- rd_in  in  RD_W  destination register
- wb_in  in  1  writeback enable
- use_imm_in  in  1  operand 2 is imm_in, broadcast to all lanes
- imm_in  in  XLEN  immediate
- rs1_data_in  in  NUM_LANES*XLEN  operand 1 per lane
- rs2_data_in  in  NUM_LANES*XLEN  operand 2 per lane
- valid_out  out  1  result valid
- ready_out  in  1  consumer accepts the result
- uuid_out, wid_out, tmask_out, PC_out, rd_out, wb_out  out  as inputs  tags passed through
- data_out  out  NUM_LANES*XLEN  per-lane result

Behaviour:
- Ops: MIN, MAX (signed); MINU, MAXU; ANDN (a&~b); ORN; XNOR; ROL, ROR (amount = b[log2(XLEN)-1:0]); CLZ; CTZ; CPOP; SEXTB; SEXTH; ZEXTH; REV8 (byte reverse); ORCB (each byte becomes 0xFF if non-zero, else 0x00).
- op encodings above 16 are undefined: result 0, tags pass through unchanged, no error.
- Operand b = imm_in when use_imm_in=1, else rs2 of the lane.
- Stage 1, registered on acceptance:
  - Latch tags and operands.
  - Compute final results for all non-count ops.
  - For count ops, compute per-byte partials: popcount (4 bits), leading-zero count, trailing-zero count, all-zero flag.
- Stage 2: combine the byte partials into CLZ/CTZ/CPOP, select the result, apply the lane mask, register the output.
- CLZ(0) = CTZ(0) = XLEN; CPOP(all ones) = XLEN; count results are zero-extended to XLEN.
- Lanes with tmask=0 output 0.
- Latency: exactly 2 cycles from acceptance (valid_in && ready_in) to valid_out when not stalled. Throughput: 1 request per cycle.
- Stall rules:
  - Stage 2 holds while valid_out && !ready_out; data_out and all tags stay stable while held.
  - Stage 1 advances into stage 2 iff stage 2 is empty or is being drained this cycle.
  - ready_in = !s1_valid || s1_advance. This is combinational, with no dependence on valid_in.
- A full pipeline under stall holds 2 requests. Simultaneous accept, advance and drain in one cycle preserves order and loses nothing.
- Reset:
  - Clears s1_valid and valid_out to 0 in the same cycle; in-flight requests are discarded.
  - ready_in is 1 on the first cycle after reset deasserts.
  - data_out and tags are unreset; their values are don't-care while valid_out=0.
- No dependence on the value of ready_out while valid_out=0.

Decomposition:
- vx_bitmanip_pkg holds:
  - bm_op_e: the 5-bit op enum.
  - Function byte_stats returning the byte popcount / lz / tz / zero flag.
  - Constants for XLEN legality checks.
- One sub-module, vx_bitmanip_lane: per-lane stage-1 compute plus stage-2 combine, instantiated NUM_LANES times. Pipeline registers and handshake logic stay in the top level.

Test Plan:
- MIN/MAX with a=0x80000000, b=0x00000001 -> MIN=0x80000000, MAX=0x00000001, MINU=0x00000001, MAXU=0x80000000; valid_out exactly 2 cycles after acceptance.
- Count ops:
  - CLZ(0) -> 32.
  - CLZ(0x00010000) -> 15.
  - CTZ(0x00010000) -> 16.
  - CPOP(0xFFFFFFFF) -> 32.
  - CPOP(0xF0F00001) -> 9.
- REV8(0x11223344) -> 0x44332211; ORCB(0x00120000) -> 0x00FF0000; ROR(0x00000001, imm=1) -> 0x80000000; SEXTB(0x80) -> 0xFFFFFF80; ZEXTH(0xABCD1234) -> 0x00001234.
- Backpressure: 3 back-to-back requests with ready_out=0:
  - Expect 2 accepted, then ready_in=0.
  - Outputs stable while held.
  - Raising ready_out drains in order, one per cycle, tags intact.
- tmask=4'b0101 with CPOP and all operands 0xFF -> lanes 0 and 2 return 8, lanes 1 and 3 return 0.
- Assert reset with 2 requests in flight -> valid_out=0 on the next cycle; the first post-reset request appears alone after 2 cycles.
